// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: opcodes, sequencer phases, widths.
package cpu_pkg;

  localparam int unsigned CPU_DATA_W = 8;
  localparam int unsigned CPU_ADDR_W = 5;

  localparam logic [2:0] HLT = 3'b000;
  localparam logic [2:0] SKZ = 3'b001;
  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] AND = 3'b011;
  localparam logic [2:0] XOR = 3'b100;
  localparam logic [2:0] LDA = 3'b101;
  localparam logic [2:0] STO = 3'b110;
  localparam logic [2:0] JMP = 3'b111;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    LOAD   = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } phase_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter with absolute load, fetch increment and skip increment.
module pc_reg #(
  parameter int unsigned ADDR_W   = 5,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  input  logic              skip,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q, pc_d;

  // Next PC: load wins; inc and skip both advance by one with natural wrap.
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (inc || skip) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  // PC state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/sequencing stage: steps FETCH-LOAD-DECODE-EXEC-WB, holds IR and PC,
// and applies the controller's registered halt/jump/skip decode in EXEC.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W   = CPU_ADDR_W,
  parameter int unsigned DATA_W   = CPU_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              acc_zero,
  input  logic              ctl_halt,
  input  logic              ctl_skz,
  input  logic              ctl_jmp,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              fetch_rd,
  output logic [2:0]        opcode,
  output logic [ADDR_W-1:0] operand,
  output logic [ADDR_W-1:0] pc,
  output logic              exec_en,
  output logic              halted
);

  phase_e            phase_q, phase_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              pc_load, pc_inc, pc_skip;

  // Phase sequencing plus IR capture and PC control; ctl_* only matter in EXEC.
  always_comb begin
    phase_d = phase_q;
    ir_d    = ir_q;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    pc_skip = 1'b0;
    unique case (phase_q)
      FETCH:  phase_d = LOAD;
      LOAD: begin
        ir_d    = mem_rdata;
        pc_inc  = 1'b1;
        phase_d = DECODE;
      end
      DECODE: phase_d = EXEC;
      EXEC: begin
        // Halt beats jump/skip and leaves the PC untouched.
        if (ctl_halt) begin
          phase_d = HALT;
        end else begin
          if (ctl_jmp) begin
            pc_load = 1'b1;
          end else if (ctl_skz && acc_zero) begin
            pc_skip = 1'b1;
          end
          phase_d = WB;
        end
      end
      WB:     phase_d = FETCH;
      HALT:   phase_d = HALT;
      default: phase_d = FETCH;
    endcase
  end

  // Phase and instruction register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= FETCH;
      ir_q    <= '0;
    end else begin
      phase_q <= phase_d;
      ir_q    <= ir_d;
    end
  end

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pc_load),
    .load_val (operand),
    .inc      (pc_inc),
    .skip     (pc_skip),
    .pc       (pc)
  );

  // Outputs decode from phase and IR only, so no input reaches an output combinationally.
  // exec_en uses the IR opcode rather than ctl_halt for the same reason.
  always_comb begin
    opcode   = ir_q[DATA_W-1 -: 3];
    operand  = ir_q[ADDR_W-1:0];
    fetch_rd = (phase_q == FETCH);
    mem_addr = (phase_q == FETCH) ? pc : operand;
    exec_en  = (phase_q == EXEC) && (opcode != HLT);
    halted   = (phase_q == HALT);
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with memory and controller models and a
// fetch/execute scoreboard.
module tb_instr_sequencer;

  logic       clk;
  logic       rst_n;
  logic       acc_zero;

  logic [7:0] mem_rdata, mem_rdata2;
  logic       ctl_halt, ctl_skz, ctl_jmp;
  logic       ctl_halt2, ctl_skz2, ctl_jmp2;
  logic [4:0] mem_addr, operand, pc;
  logic [4:0] mem_addr2, operand2, pc2;
  logic [2:0] opcode, opcode2;
  logic       fetch_rd, exec_en, halted;
  logic       fetch_rd2, exec_en2, halted2;

  logic [7:0] mem  [32];
  logic [7:0] mem2 [32];

  typedef struct {
    logic [4:0] addr;
    int         cyc;
  } fexp_t;

  typedef struct {
    logic [4:0] pc;
    logic [2:0] op;
    int         cyc;
  } eexp_t;

  fexp_t fq[$];
  eexp_t eq[$];

  int n_cmp;
  int n_err;
  int cyc;
  int nf;
  int ne;

  instr_sequencer #(
    .ADDR_W   (5),
    .DATA_W   (8),
    .RESET_PC (5'd0)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_rdata (mem_rdata),
    .acc_zero  (acc_zero),
    .ctl_halt  (ctl_halt),
    .ctl_skz   (ctl_skz),
    .ctl_jmp   (ctl_jmp),
    .mem_addr  (mem_addr),
    .fetch_rd  (fetch_rd),
    .opcode    (opcode),
    .operand   (operand),
    .pc        (pc),
    .exec_en   (exec_en),
    .halted    (halted)
  );

  // Second instance starts at the top of memory to exercise PC wrap.
  instr_sequencer #(
    .ADDR_W   (5),
    .DATA_W   (8),
    .RESET_PC (5'd31)
  ) u_dut_w (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_rdata (mem_rdata2),
    .acc_zero  (acc_zero),
    .ctl_halt  (ctl_halt2),
    .ctl_skz   (ctl_skz2),
    .ctl_jmp   (ctl_jmp2),
    .mem_addr  (mem_addr2),
    .fetch_rd  (fetch_rd2),
    .opcode    (opcode2),
    .operand   (operand2),
    .pc        (pc2),
    .exec_en   (exec_en2),
    .halted    (halted2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memories, one cycle read latency.
  always @(posedge clk) begin
    mem_rdata  <= mem[mem_addr];
    mem_rdata2 <= mem2[mem_addr2];
  end

  // Controller model: registers its decode of the opcode every cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_halt  <= 1'b0;
      ctl_skz   <= 1'b0;
      ctl_jmp   <= 1'b0;
      ctl_halt2 <= 1'b0;
      ctl_skz2  <= 1'b0;
      ctl_jmp2  <= 1'b0;
    end else begin
      ctl_halt  <= (opcode == 3'b000);
      ctl_skz   <= (opcode == 3'b001);
      ctl_jmp   <= (opcode == 3'b111);
      ctl_halt2 <= (opcode2 == 3'b000);
      ctl_skz2  <= (opcode2 == 3'b001);
      ctl_jmp2  <= (opcode2 == 3'b111);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic push_f(input logic [4:0] addr, input int c);
    fq.push_back('{addr: addr, cyc: c});
  endtask

  task automatic push_e(input logic [4:0] p, input logic [2:0] op, input int c);
    eq.push_back('{pc: p, op: op, cyc: c});
  endtask

  // Pop and compare scoreboard entries whenever the DUT strobes.
  task automatic sample();
    fexp_t f;
    eexp_t e;
    if (fetch_rd) begin
      if (fq.size() == 0) begin
        chk("fetch_unexpected", {31'd0, fetch_rd}, 32'd0);
      end else begin
        f = fq.pop_front();
        chk("fetch_addr", {27'd0, mem_addr}, {27'd0, f.addr});
        chk("fetch_cyc", cyc, f.cyc);
      end
    end
    if (exec_en) begin
      if (eq.size() == 0) begin
        chk("exec_unexpected", {31'd0, exec_en}, 32'd0);
      end else begin
        e = eq.pop_front();
        chk("exec_pc", {27'd0, pc}, {27'd0, e.pc});
        chk("exec_opcode", {29'd0, opcode}, {29'd0, e.op});
        chk("exec_cyc", cyc, e.cyc);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    sample();
  endtask

  task automatic drained(input string tag);
    chk({tag, "_fetch_left"}, fq.size(), 0);
    chk({tag, "_exec_left"}, eq.size(), 0);
    fq.delete();
    eq.delete();
  endtask

  // Cycle 1 is the FETCH presented between release and the first rising edge.
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 1;
    #1;
    sample();
  endtask

  task automatic clear_mems();
    for (int i = 0; i < 32; i++) begin
      mem[i]  = 8'h00;
      mem2[i] = 8'h00;
    end
  endtask

  task automatic prog_linear();
    clear_mems();
    mem[0] = 8'hA5;
    mem[1] = 8'h46;
    mem[2] = 8'hC7;
    mem[3] = 8'hE0;
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    cyc      = 0;
    nf       = 0;
    ne       = 0;
    acc_zero = 1'b0;
    rst_n    = 1'b0;
    clear_mems();

    // Reset values while held in reset.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", {27'd0, pc}, 32'd0);
    chk("rst_fetch_rd", {31'd0, fetch_rd}, 32'd1);
    chk("rst_mem_addr", {27'd0, mem_addr}, 32'd0);
    chk("rst_exec_en", {31'd0, exec_en}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_opcode", {29'd0, opcode}, 32'd0);
    chk("rst_operand", {27'd0, operand}, 32'd0);
    chk("rst_pc_w", {27'd0, pc2}, 32'd31);
    chk("rst_mem_addr_w", {27'd0, mem_addr2}, 32'd31);

    // Linear run ending in JMP 0; wrap instance runs ADD at 31.
    prog_linear();
    mem2[31] = 8'h40;
    push_f(5'd0, 1);  push_f(5'd1, 6);  push_f(5'd2, 11);
    push_f(5'd3, 16); push_f(5'd0, 21);
    push_e(5'd1, 3'b101, 4);  push_e(5'd2, 3'b010, 9);
    push_e(5'd3, 3'b110, 14); push_e(5'd4, 3'b111, 19);
    do_reset();
    while (cyc < 22) begin
      tick();
      if (cyc == 3) chk("wrap_add_pc", {27'd0, pc2}, 32'd0);
      if (cyc == 20) chk("jmp_pc_wb", {27'd0, pc}, 32'd0);
    end
    drained("linear");

    // SKZ taken: 0:JMP 4, 4:SKZ, 5:JMP 4, 6:JMP 4.
    clear_mems();
    mem[0] = 8'hE4; mem[4] = 8'h20; mem[5] = 8'hE4; mem[6] = 8'hE4;
    mem2[31] = 8'h20;
    acc_zero = 1'b1;
    push_f(5'd0, 1); push_f(5'd4, 6); push_f(5'd6, 11); push_f(5'd4, 16);
    push_e(5'd1, 3'b111, 4); push_e(5'd5, 3'b001, 9); push_e(5'd7, 3'b111, 14);
    do_reset();
    while (cyc < 17) begin
      tick();
      if (cyc == 5) chk("wrap_skz_pc", {27'd0, pc2}, 32'd1);
      if (cyc == 6) chk("wrap_skz_fetch", {27'd0, mem_addr2}, 32'd1);
      if (cyc == 10) chk("skz_taken_pc", {27'd0, pc}, 32'd6);
    end
    drained("skz_taken");

    // SKZ not taken.
    acc_zero = 1'b0;
    push_f(5'd0, 1); push_f(5'd4, 6); push_f(5'd5, 11); push_f(5'd4, 16);
    push_e(5'd1, 3'b111, 4); push_e(5'd5, 3'b001, 9); push_e(5'd6, 3'b111, 14);
    do_reset();
    while (cyc < 17) begin
      tick();
      if (cyc == 5) chk("wrap_skz_nt_pc", {27'd0, pc2}, 32'd0);
      if (cyc == 10) chk("skz_not_taken_pc", {27'd0, pc}, 32'd5);
    end
    drained("skz_not_taken");

    // HLT at address 2, then 20 quiet cycles.
    clear_mems();
    mem[0] = 8'h40; mem[1] = 8'h40; mem[2] = 8'h00;
    push_f(5'd0, 1); push_f(5'd1, 6); push_f(5'd2, 11);
    push_e(5'd1, 3'b010, 4); push_e(5'd2, 3'b010, 9);
    do_reset();
    nf = 0;
    ne = 0;
    while (cyc < 35) begin
      tick();
      if (cyc == 14) chk("hlt_exec_halted", {31'd0, halted}, 32'd0);
      if (cyc >= 15) begin
        chk("halted_hold", {31'd0, halted}, 32'd1);
        if (fetch_rd) nf++;
        if (exec_en) ne++;
      end
    end
    chk("halt_fetch_count", nf, 0);
    chk("halt_exec_count", ne, 0);
    chk("halt_pc", {27'd0, pc}, 32'd3);
    drained("halt");

    // Asynchronous reset out of HALT.
    rst_n = 1'b0;
    #1;
    chk("halt_rst_halted", {31'd0, halted}, 32'd0);
    chk("halt_rst_fetch_rd", {31'd0, fetch_rd}, 32'd1);
    chk("halt_rst_pc", {27'd0, pc}, 32'd0);

    // Reset pulse in the middle of a LOAD phase.
    prog_linear();
    push_f(5'd0, 1); push_f(5'd1, 6);
    push_e(5'd1, 3'b101, 4);
    do_reset();
    while (cyc < 7) tick();
    chk("pre_pulse_pc", {27'd0, pc}, 32'd1);
    chk("pre_pulse_fetch_rd", {31'd0, fetch_rd}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("pulse_fetch_rd", {31'd0, fetch_rd}, 32'd1);
    chk("pulse_pc", {27'd0, pc}, 32'd0);
    chk("pulse_mem_addr", {27'd0, mem_addr}, 32'd0);
    chk("pulse_opcode", {29'd0, opcode}, 32'd0);
    #1;
    rst_n = 1'b1;
    drained("pre_pulse");
    push_f(5'd0, 1); push_f(5'd1, 6);
    push_e(5'd1, 3'b101, 4);
    cyc = 1;
    #1;
    sample();
    while (cyc < 7) tick();
    drained("post_pulse");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
